// File: rtl/filter_window_3x3.sv
// filter_window_3x3: streaming 3x3 neighbourhood generator with two line buffers.
// Optional WINDOW_SOF_EN adds a sof input that realigns the frame on an accepted pixel.
module filter_window_3x3 #(
    parameter int LINE_WIDTH = 100,
    parameter int DATA_W     = 8
) (
    input  logic              sclk,
    input  logic              s_rst,
`ifdef WINDOW_SOF_EN
    input  logic              sof,
`endif
    input  logic [DATA_W-1:0] din,
    input  logic              data_valuable,
    output logic [DATA_W-1:0] Data00,
    output logic [DATA_W-1:0] Data01,
    output logic [DATA_W-1:0] Data02,
    output logic [DATA_W-1:0] Data10,
    output logic [DATA_W-1:0] Data11,
    output logic [DATA_W-1:0] Data12,
    output logic [DATA_W-1:0] Data20,
    output logic [DATA_W-1:0] Data21,
    output logic [DATA_W-1:0] Data22,
    output logic              dout_flag
);
    localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    logic [CW-1:0] col_cnt, col_nxt, ptr;
    logic [1:0] row_cnt, row_nxt;
    logic start, last, flag_nxt;
    logic [DATA_W-1:0] lb1 [LINE_WIDTH];
    logic [DATA_W-1:0] lb2 [LINE_WIDTH];
    logic [DATA_W-1:0] lb1_q, lb2_q;
    logic [DATA_W-1:0] w [3][3];
`ifdef WINDOW_SOF_EN
    assign start = sof;
`else
    assign start = 1'b0;
`endif
    assign lb1_q = lb1[ptr];
    assign lb2_q = lb2[ptr];
    always_comb begin
        last     = col_cnt == CW'(LINE_WIDTH - 1);
        col_nxt  = start ? CW'(1) : last ? '0 : col_cnt + 1'b1;
        row_nxt  = start ? 2'd0 : (last && row_cnt != 2'd2) ? row_cnt + 1'b1 : row_cnt;
        flag_nxt = !start && row_cnt == 2'd2 && col_cnt >= CW'(2);
    end
    // Line-buffer pointer runs independently of sof so each buffer is always exactly one line deep.
    always_ff @(posedge sclk) begin
        if (data_valuable) begin
            lb1[ptr] <= din;
            lb2[ptr] <= lb1_q;
        end
    end
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            ptr       <= '0;
            dout_flag <= 1'b0;
            w         <= '{default: '0};
        end else begin
            dout_flag <= data_valuable && flag_nxt;
            if (data_valuable) begin
                col_cnt <= col_nxt;
                row_cnt <= row_nxt;
                ptr     <= (ptr == CW'(LINE_WIDTH - 1)) ? '0 : ptr + 1'b1;
                for (int r = 0; r < 3; r++) begin
                    w[r][0] <= w[r][1];
                    w[r][1] <= w[r][2];
                end
                w[0][2] <= lb2_q;
                w[1][2] <= lb1_q;
                w[2][2] <= din;
            end
        end
    end
    assign {Data00, Data01, Data02} = {w[0][0], w[0][1], w[0][2]};
    assign {Data10, Data11, Data12} = {w[1][0], w[1][1], w[1][2]};
    assign {Data20, Data21, Data22} = {w[2][0], w[2][1], w[2][2]};
endmodule

// File: tb/tb_filter_window_3x3.sv
// tb_filter_window_3x3: directed checks of the 3x3 window generator at LINE_WIDTH 8 and 100.
module tb_filter_window_3x3;
    logic sclk = 1'b0;
    logic s_rst = 1'b1;
    logic sof = 1'b0;
    logic [7:0] din = '0;
    logic data_valuable = 1'b0;
    logic [7:0] q00, q01, q02, q10, q11, q12, q20, q21, q22;
    logic [7:0] r00, r01, r02, r10, r11, r12, r20, r21, r22;
    logic q_flag, r_flag;
    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 sclk = ~sclk;

    filter_window_3x3 #(.LINE_WIDTH(8), .DATA_W(8)) dut8 (
        .sclk(sclk), .s_rst(s_rst),
`ifdef WINDOW_SOF_EN
        .sof(sof),
`endif
        .din(din), .data_valuable(data_valuable),
        .Data00(q00), .Data01(q01), .Data02(q02),
        .Data10(q10), .Data11(q11), .Data12(q12),
        .Data20(q20), .Data21(q21), .Data22(q22),
        .dout_flag(q_flag)
    );

    filter_window_3x3 #(.LINE_WIDTH(100), .DATA_W(8)) dut100 (
        .sclk(sclk), .s_rst(s_rst),
`ifdef WINDOW_SOF_EN
        .sof(1'b0),
`endif
        .din(din), .data_valuable(data_valuable),
        .Data00(r00), .Data01(r01), .Data02(r02),
        .Data10(r10), .Data11(r11), .Data12(r12),
        .Data20(r20), .Data21(r21), .Data22(r22),
        .dout_flag(r_flag)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        din = 8'(v);
        data_valuable = 1'b1;
        @(posedge sclk);
        #1;
        data_valuable = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d0x"}, int'({q00, q01, q02}), 0);
        chk({tag, "_d1x"}, int'({q10, q11, q12}), 0);
        chk({tag, "_d2x"}, int'({q20, q21, q22}), 0);
        chk({tag, "_flag"}, int'(q_flag), 0);
    endtask

    task automatic first_window(input string tag);
        for (int p = 0; p < 18; p++) begin
            push(p);
            chk({tag, "_early_flag"}, int'(q_flag), 0);
        end
        push(18);
        chk({tag, "_flag18"}, int'(q_flag), 1);
        chk({tag, "_d00"}, int'(q00), 0);
        chk({tag, "_d01"}, int'(q01), 1);
        chk({tag, "_d02"}, int'(q02), 2);
        chk({tag, "_d10"}, int'(q10), 8);
        chk({tag, "_d11"}, int'(q11), 9);
        chk({tag, "_d12"}, int'(q12), 10);
        chk({tag, "_d20"}, int'(q20), 16);
        chk({tag, "_d21"}, int'(q21), 17);
        chk({tag, "_d22"}, int'(q22), 18);
    endtask

    initial begin
        repeat (2) @(posedge sclk);
        #1;
        chk_zero("reset");
        s_rst = 1'b0;
        first_window("ramp");
        push(19);
        chk("flag19", int'(q_flag), 1);
        push(20);
        chk("flag20", int'(q_flag), 1);
        repeat (3) @(posedge sclk);
        #1;
        chk("stall_d22", int'(q22), 20);
        chk("stall_d12", int'(q12), 12);
        chk("stall_d02", int'(q02), 4);
        chk("stall_flag", int'(q_flag), 0);
        push(21);
        chk("resume_d22", int'(q22), 21);
        chk("resume_d12", int'(q12), 13);
        chk("resume_d02", int'(q02), 5);
        chk("resume_flag", int'(q_flag), 1);
        push(22);
        chk("flag22", int'(q_flag), 1);
        push(23);
        chk("flag23", int'(q_flag), 1);
        push(24);
        chk("flag24_col0", int'(q_flag), 0);
        push(25);
        chk("flag25_col1", int'(q_flag), 0);
        push(26);
        chk("flag26", int'(q_flag), 1);
        chk("p26_d00", int'(q00), 8);
        chk("p26_d11", int'(q11), 17);
        chk("p26_d22", int'(q22), 26);
        for (int p = 27; p <= 30; p++) push(p);
        chk("p30_d22", int'(q22), 30);
        #2 s_rst = 1'b1;
        #1;
        chk_zero("async_rst");
        repeat (2) @(posedge sclk);
        #1;
        s_rst = 1'b0;
        first_window("rerun");

        s_rst = 1'b1;
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
        chk("w100_rst_flag", int'(r_flag), 0);
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            push(i);
            if (r_flag) begin
                pulses++;
                chk("w100_d22_d12", int'(8'(r22 - r12)), 100);
                chk("w100_d12_d02", int'(8'(r12 - r02)), 100);
            end
        end
        chk("w100_pulses", pulses, 784);

`ifdef WINDOW_SOF_EN
        s_rst = 1'b1;
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
        for (int p = 0; p < 20; p++) push(p);
        chk("sof_pre_flag", int'(q_flag), 1);
        sof = 1'b1;
        push(20);
        sof = 1'b0;
        chk("sof_edge_flag", int'(q_flag), 0);
        for (int p = 21; p <= 37; p++) begin
            push(p);
            chk("sof_early_flag", int'(q_flag), 0);
        end
        push(38);
        chk("sof_flag19", int'(q_flag), 1);
        chk("sof_d22", int'(q22), 38);
        chk("sof_d12", int'(q12), 30);
        chk("sof_d02", int'(q02), 22);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
